// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and frame timing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int BIT_CYCLES = 5000;
  localparam int FRAME_BITS = 10;
  localparam int DATA_W     = 8;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Round-robin picker: first asserted request searching upward from ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   winner_idx,
  output logic               found
);

  always_comb begin
    int j;
    j          = 0;
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found      = 1'b1;
        winner[j]  = 1'b1;
        winner_idx = j[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one UART transmitter between
// NUM_REQ byte streams, with a watchdog that revokes a stalled grant.
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int STALL_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      abort,
  output logic                      idle
);
  import uart_pkg::*;

  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W = $clog2(STALL_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_CYCLES - 1);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q;
  logic [PW-1:0]       owner_q, rr_ptr_q;
  logic [WD_W-1:0]     wd_q;
  logic                last_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_start_q, abort_q;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [PW-1:0]       pick_idx;
  logic                pick_found;
  logic                accept, stall, release_grant;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + PW'(1);
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PW)) u_pick (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  always_comb begin
    req_ready = '0;
    if (state_q == SEND && !tx_busy) req_ready[owner_q] = 1'b1;
  end

  assign accept        = (state_q == SEND) && !tx_busy && req_valid[owner_q];
  // Watchdog only runs while the owner is expected to offer a byte.
  assign stall         = (state_q == SEND) && !accept && (wd_q == WD_LIMIT);
  assign release_grant = (state_q == WAIT_DONE) && !tx_busy && last_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick_found) state_d = SEND;
      SEND: begin
        if (accept)     state_d = WAIT_ACK;
        else if (stall) state_d = IDLE;
      end
      WAIT_ACK:  if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = last_q ? IDLE : SEND;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      wd_q       <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= accept;
      abort_q    <= stall;
      if (state_q == IDLE && pick_found) begin
        grant_q <= pick_onehot;
        owner_q <= pick_idx;
      end
      if (stall || release_grant) begin
        grant_q  <= '0;
        rr_ptr_q <= wrap_inc(owner_q);
      end
      if (accept) begin
        tx_data_q <= req_data[int'(owner_q)*DATA_W +: DATA_W];
        last_q    <= req_last[owner_q];
      end
      // Count resets on every entry to SEND and saturates rather than wrapping.
      if (state_q != SEND || accept) wd_q <= '0;
      else if (wd_q != '1)           wd_q <= wd_q + WD_W'(1);
    end
  end

  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign abort    = abort_q;
  assign idle     = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a packet-level round-robin model.
module tb_uart_tx_sched;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int STALL = 64;

  typedef struct packed {logic [DW-1:0] d; logic l;} item_t;
  typedef struct {int who; logic [DW-1:0] d;} exp_t;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR-1:0]    req_ready, grant;
  logic [DW-1:0]    tx_data;
  logic             tx_start, abort, idle, tx_busy;

  int   busy_cnt = 0, busy_lo = 3, busy_hi = 10;
  logic force_busy = 1'b0;

  int n_tests = 0, n_fail = 0, cyc = 0, n_abort = 0, ready_viol = 0, mptr = 0;
  item_t rq[NR][$];
  item_t mq[NR][$];
  exp_t  exp_q[$];
  logic [NR-1:0] first_pkt = '1;

  always #5 clk = ~clk;

  // Transmitter model: busy from the cycle after tx_start for a random length.
  assign tx_busy = (busy_cnt != 0) || force_busy;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= int'($urandom_range(busy_hi, busy_lo));
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .STALL_CYCLES(STALL)) dut (
    .clk       (clk),
    .res       (res),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .abort     (abort),
    .idle      (idle)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_item(input int i, input logic [DW-1:0] d, input logic l);
    rq[i].push_back('{d: d, l: l});
    mq[i].push_back('{d: d, l: l});
  endtask

  // Packet-level model: whole packets handed out round-robin from mptr.
  task automatic model_run();
    bit any;
    int i;
    item_t it;
    do begin
      any = 0;
      for (int k = 0; k < NR; k++) if (mq[k].size() > 0) any = 1;
      if (any) begin
        i = mptr;
        while (mq[i].size() == 0) i = (i + 1) % NR;
        do begin
          it = mq[i].pop_front();
          exp_q.push_back('{who: i, d: it.d});
        end while (!it.l && mq[i].size() > 0);
        mptr = (i + 1) % NR;
      end
    end while (any);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NR; k++) if (rq[k].size() > 0) return 0;
    return 1;
  endfunction

  task automatic flush_all();
    for (int k = 0; k < NR; k++) begin
      rq[k].delete();
      mq[k].delete();
    end
    exp_q.delete();
    first_pkt = '1;
  endtask

  // One clock: drive at negedge, sample handshake just before posedge,
  // then observe outputs at the following negedge.
  task automatic tick();
    logic [NR-1:0]    v, l, acc;
    logic [NR*DW-1:0] d;
    item_t it;
    exp_t  e;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NR; i++) begin
      d[i*DW +: DW] = 8'($urandom);
      if (rq[i].size() > 0 && (first_pkt[i] || $urandom_range(3, 0) != 0)) begin
        v[i] = 1'b1;
        d[i*DW +: DW] = rq[i][0].d;
        l[i] = rq[i][0].l;
      end
    end
    req_valid = v; req_data = d; req_last = l;
    #4;
    acc = req_valid & req_ready;
    if ((req_ready & {NR{tx_busy}}) != '0 || $countones(req_ready) > 1) ready_viol++;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        it = rq[i].pop_front();
        first_pkt[i] = it.l;
      end
    end
    if (abort) n_abort++;
    if (tx_start) begin
      if (exp_q.size() == 0) check("tx_start_unexpected", 32'(tx_start), 32'(0));
      else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.d));
        check("grant_at_start", 32'(grant), 32'(1) << e.who);
      end
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && all_empty() && idle && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(n < budget), 32'(1));
    check({tag, "_idle"}, 32'(idle), 32'(1));
  endtask

  initial begin
    int n, cyc_f, npk, len;
    logic [NR-1:0] mask;

    @(negedge clk);
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_tx_start", 32'(tx_start), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    check("rst_abort", 32'(abort), 32'(0));
    check("rst_idle", 32'(idle), 32'(1));
    res = 1'b0;

    // Single packet from requester 1 with long frames.
    busy_lo = 2000; busy_hi = 2000;
    push_item(1, 8'h09, 1'b0);
    push_item(1, 8'h06, 1'b0);
    push_item(1, 8'h0A, 1'b1);
    model_run();
    tick();
    check("single_grant", 32'(grant), 32'(4'b0010));
    drain(10000, "single");

    // Round robin from reset, twice.
    busy_lo = 3; busy_hi = 8;
    res = 1'b1; tick(); res = 1'b0; mptr = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) push_item(i, 8'($urandom), 1'b1);
      model_run();
      drain(2000, "rr");
    end

    // Random packet mixes.
    busy_lo = 2; busy_hi = 12;
    for (int r = 0; r < 5; r++) begin
      mask = 4'($urandom_range(15, 1));
      for (int i = 0; i < NR; i++) begin
        if (mask[i]) begin
          npk = int'($urandom_range(2, 1));
          for (int p = 0; p < npk; p++) begin
            len = int'($urandom_range(4, 1));
            for (int b = 0; b < len; b++) push_item(i, 8'($urandom), b == len - 1);
          end
        end
      end
      model_run();
      drain(4000, "rand");
    end

    // Packet lock: requester 0 arrives while requester 2 owns the transmitter.
    push_item(2, 8'h5A, 1'b0);
    push_item(2, 8'hA5, 1'b1);
    model_run();
    n = 0;
    while (!tx_start && n < 500) begin tick(); n++; end
    check("lock_first_start", 32'(tx_start), 32'(1));
    push_item(0, 8'h3C, 1'b1);
    model_run();
    check("lock_owner", 32'(grant), 32'(4'b0100));
    drain(2000, "lock");

    // Watchdog: requester 3 sends a non-last byte then goes silent.
    push_item(3, 8'h77, 1'b0);
    model_run();
    n = 0;
    while (!tx_start && n < 500) begin tick(); n++; end
    while (!tx_busy && n < 500) begin tick(); n++; end
    while (tx_busy && n < 500) begin tick(); n++; end
    cyc_f = cyc;
    n = 0;
    while (!abort && n < STALL + 50) begin tick(); n++; end
    check("wd_delay", 32'(cyc - cyc_f), 32'(STALL + 1));
    check("wd_grant", 32'(grant), 32'(0));
    check("wd_idle", 32'(idle), 32'(1));
    first_pkt[3] = 1'b1;
    tick();
    check("wd_abort_pulse", 32'(abort), 32'(0));
    push_item(1, 8'h11, 1'b1);
    push_item(0, 8'h22, 1'b1);
    model_run();
    drain(2000, "wd_after");

    // Hold-off: transmitter busy while in SEND.
    force_busy = 1'b1;
    push_item(1, 8'hC3, 1'b1);
    model_run();
    tick();
    n = 0;
    repeat (20) begin
      tick();
      if (req_ready != '0 || tx_start) n++;
    end
    check("holdoff_quiet", 32'(n), 32'(0));
    check("holdoff_grant", 32'(grant), 32'(4'b0010));
    force_busy = 1'b0;
    drain(2000, "holdoff");

    // Reset during WAIT_DONE, then pointer must restart at 0.
    push_item(2, 8'hE1, 1'b0);
    push_item(2, 8'hE2, 1'b1);
    model_run();
    n = 0;
    while (!tx_start && n < 500) begin tick(); n++; end
    while (!tx_busy && n < 500) begin tick(); n++; end
    tick(); tick();
    flush_all();
    res = 1'b1;
    tick();
    check("mid_rst_grant", 32'(grant), 32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    check("mid_rst_tx_start", 32'(tx_start), 32'(0));
    check("mid_rst_tx_data", 32'(tx_data), 32'(0));
    check("mid_rst_abort", 32'(abort), 32'(0));
    check("mid_rst_idle", 32'(idle), 32'(1));
    res = 1'b0; mptr = 0;
    push_item(3, 8'h33, 1'b1);
    push_item(1, 8'h44, 1'b1);
    model_run();
    drain(2000, "post_rst");

    check("abort_count", 32'(n_abort), 32'(1));
    check("ready_rules", 32'(ready_viol), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
